// File: rtl/uart_tx_arb_if.sv
// uart_tx_arb_if -- handshake bundle between byte requesters and the UART
// launch arbiter.
//   master modport : requester side, drives en/req/req_data, sees grant results
//   slave modport  : arbiter side, consumes requests, drives ack/tx_*/busy/grant_id
// Signals:
//   en        new grants allowed
//   req       per-requester byte-pending flag (held until ack)
//   req_data  byte of requester i on bits [8i+7:8i]
//   ack       one-cycle accept pulse, one-hot or zero
//   tx_send   one-cycle launch pulse to the transmitter
//   tx_data   launched byte, held until the next launch
//   busy      high for the whole frame window
//   grant_id  most recently granted requester
interface uart_tx_arb_if #(
  parameter int NREQ = 4
);
  logic                    en;
  logic [NREQ-1:0]         req;
  logic [8*NREQ-1:0]       req_data;
  logic [NREQ-1:0]         ack;
  logic                    tx_send;
  logic [7:0]              tx_data;
  logic                    busy;
  logic [$clog2(NREQ)-1:0] grant_id;

  modport master (
    output en, req, req_data,
    input  ack, tx_send, tx_data, busy, grant_id
  );

  modport slave (
    input  en, req, req_data,
    output ack, tx_send, tx_data, busy, grant_id
  );
endinterface

// File: rtl/uart_tx_arb.sv
// uart_tx_arb -- round-robin arbiter that launches one byte per UART frame
// window. A grant produces a single-cycle tx_send/ack pair, then further
// grants are held off until FRAME_CYCLES cycles (launch cycle included) have
// elapsed, so back-to-back launches are exactly FRAME_CYCLES apart.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  uart_tx_arb_if.slave (en, req, req_data in; ack, tx_send, tx_data,
//        busy, grant_id out -- all outputs registered)
module uart_tx_arb #(
  parameter int NREQ         = 4,
  parameter int FRAME_CYCLES = 160
) (
  input logic          clk,
  input logic          rst,
  uart_tx_arb_if.slave bus
);

  localparam int         IDW      = $clog2(NREQ);
  localparam logic [9:0] LAST_CNT = 10'(FRAME_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01
  } state_t;

  state_t          state_q, state_d;
  logic [9:0]      cnt_q, cnt_d;
  logic            tx_send_q, tx_send_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            busy_q, busy_d;
  logic [IDW-1:0]  grant_id_q, grant_id_d;

  // Round-robin pick: first set req bit scanning grant_id+1, grant_id+2, ...
  // The index wraps naturally because NREQ is a power of two.
  logic           found;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] idx;

  always_comb begin
    found  = 1'b0;
    winner = grant_id_q;
    idx    = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = grant_id_q + IDW'(k);
      if (!found && bus.req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // The counter marks the launch cycle as 1. WAIT covers cycles
  // 1..FRAME_CYCLES-1; the last window cycle is spent back in IDLE with busy
  // still registered high, so a pending request is granted on that edge and
  // the next launch lands exactly FRAME_CYCLES after the previous one.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_send_d  = 1'b0;
    ack_d      = '0;
    tx_data_d  = tx_data_q;
    busy_d     = 1'b0;
    grant_id_d = grant_id_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.en && found) begin
          state_d       = WAIT;
          cnt_d         = 10'd1;
          tx_send_d     = 1'b1;
          ack_d[winner] = 1'b1;
          tx_data_d     = bus.req_data[{winner, 3'b000} +: 8];
          grant_id_d    = winner;
          busy_d        = 1'b1;
        end
      end
      WAIT: begin
        busy_d = 1'b1;
        if (cnt_q >= LAST_CNT) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tx_send_q  <= 1'b0;
      ack_q      <= '0;
      tx_data_q  <= 8'h00;
      busy_q     <= 1'b0;
      grant_id_q <= '1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_send_q  <= tx_send_d;
      ack_q      <= ack_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      grant_id_q <= grant_id_d;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.tx_send  = tx_send_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.busy     = busy_q;
  assign bus.grant_id = grant_id_q;

endmodule
